ahbl_sram_responder: RTL and testbench

AHBL_SRAM_RESPONDER -- requirements
Module: ahbl_sram_responder

---
 rtl/ahbl_pkg.sv | 46 ++++
 rtl/ahbl_sram_responder_if.sv | 31 +++
 rtl/sram_1r1w_bytemask.sv | 31 +++
 rtl/ahbl_sram_responder.sv | 180 ++++++++++++++++++
 tb/tb_ahbl_sram_responder.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/ahbl_pkg.sv
// Shared AHB-Lite definitions for the SRAM responder: HTRANS/HSIZE/HBURST
// encodings, the responder state enum and byte-lane helpers.
// Optional build macro: AHBL_SRAM_ERR_RESP_EN adds the ERR1/ERR2 states.
package ahbl_pkg;

  localparam logic [1:0] HTRANS_IDLE = 2'd0;
  localparam logic [1:0] HTRANS_BUSY = 2'd1;
  localparam logic [1:0] HTRANS_NSEQ = 2'd2;
  localparam logic [1:0] HTRANS_SEQ  = 2'd3;

  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

  localparam logic [2:0] HBURST_SINGLE = 3'd0;
  localparam logic [2:0] HBURST_INCR   = 3'd1;
  localparam logic [2:0] HBURST_WRAP4  = 3'd2;

`ifdef AHBL_SRAM_ERR_RESP_EN
  typedef enum logic [2:0] {ST_IDLE, ST_WAIT, ST_DATA, ST_ERR1, ST_ERR2} state_t;
`else
  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DATA} state_t;
`endif

  // Sizes above a word, or a halfword/word not naturally aligned.
  function automatic logic xfer_illegal(input logic [2:0] size, input logic [1:0] lane);
    return (size > HSIZE_WORD) ||
           ((size == HSIZE_HALF) && lane[0]) ||
           ((size == HSIZE_WORD) && (lane != 2'b00));
  endfunction

  // Byte-lane enables for a transfer; illegal transfers touch no lane.
  function automatic logic [3:0] lane_mask(input logic [2:0] size, input logic [1:0] lane);
    logic [3:0] m;
    m = 4'b0000;
    case (size)
      HSIZE_BYTE: m = 4'b0001 << lane;
      HSIZE_HALF: m = lane[1] ? 4'b1100 : 4'b0011;
      HSIZE_WORD: m = 4'b1111;
      default:    m = 4'b0000;
    endcase
    if (xfer_illegal(size, lane)) m = 4'b0000;
    return m;
  endfunction

endpackage

// File: rtl/ahbl_sram_responder_if.sv
// AHB-Lite responder bus bundle. The fabric-level hready is carried here too;
// the master side (or interconnect) drives it.
interface ahbl_sram_responder_if #(
  parameter int W_HADDR = 32,
  parameter int W_HDATA = 32
);
  logic               ahbls_hready;
  logic               ahbls_hready_resp;
  logic               ahbls_hresp;
  logic [W_HADDR-1:0] ahbls_haddr;
  logic               ahbls_hwrite;
  logic [1:0]         ahbls_htrans;
  logic [2:0]         ahbls_hsize;
  logic [2:0]         ahbls_hburst;
  logic [3:0]         ahbls_hprot;
  logic               ahbls_hmastlock;
  logic [W_HDATA-1:0] ahbls_hwdata;
  logic [W_HDATA-1:0] ahbls_hrdata;

  modport master (
    output ahbls_haddr, ahbls_hwrite, ahbls_htrans, ahbls_hsize, ahbls_hburst,
           ahbls_hprot, ahbls_hmastlock, ahbls_hwdata,
    input  ahbls_hready, ahbls_hready_resp, ahbls_hresp, ahbls_hrdata
  );

  modport slave (
    input  ahbls_hready, ahbls_haddr, ahbls_hwrite, ahbls_htrans, ahbls_hsize,
           ahbls_hburst, ahbls_hprot, ahbls_hmastlock, ahbls_hwdata,
    output ahbls_hready_resp, ahbls_hresp, ahbls_hrdata
  );
endinterface

// File: rtl/sram_1r1w_bytemask.sv
// Synchronous word memory with one read port and one byte-masked write port.
// Read data is registered (one-cycle latency); contents are never reset.
// Kept as a separate module so a vendor macro can replace it.
module sram_1r1w_bytemask #(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH),
  parameter int NB    = 4
) (
  input  logic            clk,
  input  logic [AW-1:0]   rd_addr,
  output logic [NB*8-1:0] rd_data,
  input  logic            we,
  input  logic [NB-1:0]   wr_mask,
  input  logic [AW-1:0]   wr_addr,
  input  logic [NB*8-1:0] wr_data
);

  for (genvar gi = 0; gi < NB; gi++) begin : g_lane
    logic [7:0] mem [DEPTH];
    logic [7:0] q_reg;

    // One byte lane: masked write, read-first registered read.
    always_ff @(posedge clk) begin
      if (we && wr_mask[gi]) mem[wr_addr] <= wr_data[gi*8 +: 8];
      q_reg <= mem[rd_addr];
    end

    assign rd_data[gi*8 +: 8] = q_reg;
  end

endmodule

// File: rtl/ahbl_sram_responder.sv
// AHB-Lite SRAM responder: NSEQ transfers take WAIT_CYCLES wait states, SEQ
// beats are zero-wait, address and data phases pipeline back to back.
// Optional build macro: AHBL_SRAM_ERR_RESP_EN -- illegal transfers get a
// two-cycle ERROR response; without it they complete OKAY, writes are
// dropped and reads return zero.
module ahbl_sram_responder
  import ahbl_pkg::*;
#(
  parameter int W_HADDR     = 32,
  parameter int W_HDATA     = 32,
  parameter int DEPTH       = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input logic                 clk,
  input logic                 rst,
  ahbl_sram_responder_if.slave bus
);

  localparam int         AW        = $clog2(DEPTH);
  localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  state_t state_reg, state_next;
  logic [3:0] cnt_reg, cnt_next;

  logic [AW-1:0]      addr_idx_reg;
  logic               write_reg;
  logic               illegal_reg;
  logic [3:0]         mask_reg;
  logic [3:0]         byp_mask_reg;
  logic [W_HDATA-1:0] byp_data_reg;
  logic [W_HDATA-1:0] hold_reg;

  logic [W_HADDR-1:0] haddr;
  logic [W_HDATA-1:0] wdata;
  logic [AW-1:0]      live_idx;
  logic [1:0]         live_lane;
  logic               live_illegal;
  logic               accept_slot;
  logic               capture;
  logic               data_phase;
  logic               rd_phase;
  logic               sram_we;
  logic [AW-1:0]      rd_idx;
  logic [W_HDATA-1:0] sram_q;
  logic [W_HDATA-1:0] merged;
  logic [W_HDATA-1:0] rd_word;
  logic               unused_bits;

  assign haddr        = bus.ahbls_haddr;
  assign wdata        = bus.ahbls_hwdata;
  assign live_idx     = haddr[AW+1:2];
  assign live_lane    = haddr[1:0];
  assign live_illegal = xfer_illegal(bus.ahbls_hsize, live_lane);

  // Upper address bits alias; protection, lock and burst type do not matter.
  assign unused_bits = ^{bus.ahbls_hburst, bus.ahbls_hprot, bus.ahbls_hmastlock, haddr};

  // A new address phase may only be taken while this responder shows ready.
`ifdef AHBL_SRAM_ERR_RESP_EN
  assign accept_slot = (state_reg == ST_IDLE) || (state_reg == ST_DATA) || (state_reg == ST_ERR2);
`else
  assign accept_slot = (state_reg == ST_IDLE) || (state_reg == ST_DATA);
`endif
  assign capture = accept_slot && bus.ahbls_hready && bus.ahbls_htrans[1];

  assign data_phase = (state_reg == ST_DATA);
  assign rd_phase   = data_phase && !write_reg;
  // A reset arriving during the write data phase blocks the commit.
  assign sram_we    = data_phase && write_reg && !rst && (mask_reg != 4'b0000);

  // Reads are issued one cycle ahead: from the live bus when the data phase
  // follows immediately, otherwise from the captured address during WAIT.
  assign rd_idx = capture ? live_idx : addr_idx_reg;

  // State and wait counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= 4'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Next-state and wait-counter logic.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      ST_WAIT: begin
        if (cnt_reg == 4'd0) state_next = ST_DATA;
        else                 cnt_next   = cnt_reg - 4'd1;
      end
`ifdef AHBL_SRAM_ERR_RESP_EN
      ST_ERR1: state_next = ST_ERR2;
`endif
      default: begin
        // IDLE, DATA (and ERR2): finish here, or move into the next transfer.
        state_next = ST_IDLE;
        if (capture) begin
          if ((bus.ahbls_htrans == HTRANS_NSEQ) && (WAIT_CYCLES > 0)) begin
            state_next = ST_WAIT;
            cnt_next   = WAIT_LOAD;
          end else begin
            state_next = ST_DATA;
          end
`ifdef AHBL_SRAM_ERR_RESP_EN
          if (live_illegal) begin
            state_next = ST_ERR1;
            cnt_next   = cnt_reg;
          end
`endif
        end
      end
    endcase
  end

  // Address-phase capture of the attributes needed in the data phase.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_idx_reg <= '0;
      write_reg    <= 1'b0;
      illegal_reg  <= 1'b0;
      mask_reg     <= 4'b0000;
    end else if (capture) begin
      addr_idx_reg <= live_idx;
      write_reg    <= bus.ahbls_hwrite;
      illegal_reg  <= live_illegal;
      mask_reg     <= lane_mask(bus.ahbls_hsize, live_lane);
    end
  end

  // Remember bytes written in the same cycle a read of that word was issued,
  // since the registered read returns the pre-write contents.
  always_ff @(posedge clk) begin
    if (rst) begin
      byp_mask_reg <= 4'b0000;
    end else begin
      byp_mask_reg <= (sram_we && (rd_idx == addr_idx_reg)) ? mask_reg : 4'b0000;
    end
    byp_data_reg <= wdata;
  end

  sram_1r1w_bytemask #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .NB    (4)
  ) u_sram (
    .clk     (clk),
    .rd_addr (rd_idx),
    .rd_data (sram_q),
    .we      (sram_we),
    .wr_mask (mask_reg),
    .wr_addr (addr_idx_reg),
    .wr_data (wdata)
  );

  for (genvar gi = 0; gi < 4; gi++) begin : g_merge
    assign merged[gi*8 +: 8] = byp_mask_reg[gi] ? byp_data_reg[gi*8 +: 8] : sram_q[gi*8 +: 8];
  end

  assign rd_word = illegal_reg ? '0 : merged;

  // Read data is held on the bus between read data phases.
  always_ff @(posedge clk) begin
    if (rst)           hold_reg <= '0;
    else if (rd_phase) hold_reg <= rd_word;
  end

  assign bus.ahbls_hrdata = rd_phase ? rd_word : hold_reg;
`ifdef AHBL_SRAM_ERR_RESP_EN
  assign bus.ahbls_hready_resp = !((state_reg == ST_WAIT) || (state_reg == ST_ERR1));
  assign bus.ahbls_hresp       = (state_reg == ST_ERR1) || (state_reg == ST_ERR2);
`else
  assign bus.ahbls_hready_resp = (state_reg != ST_WAIT);
  assign bus.ahbls_hresp       = 1'b0;
`endif

endmodule

// File: tb/tb_ahbl_sram_responder.sv
// Directed bench for ahbl_sram_responder (WAIT_CYCLES=2). The driver pushes
// the expected response of each beat into a queue when issuing it; a monitor
// follows address/data phases on the bus and pops/compares at each completion.
// Honours AHBL_SRAM_ERR_RESP_EN for the illegal-transfer expectations.
module tb_ahbl_sram_responder;
  import ahbl_pkg::*;

  localparam int WAITS = 2;
`ifdef AHBL_SRAM_ERR_RESP_EN
  localparam logic ILL_RESP  = 1'b1;
  localparam int   ILL_WAITS = 1;
`else
  localparam logic ILL_RESP  = 1'b0;
  localparam int   ILL_WAITS = WAITS;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic stall = 1'b0;
  logic [2:0] cur_burst = HBURST_SINGLE;

  always #5 clk = ~clk;

  ahbl_sram_responder_if #(.W_HADDR(32), .W_HDATA(32)) bus ();
  assign bus.ahbls_hready = bus.ahbls_hready_resp & ~stall;

  ahbl_sram_responder #(
    .W_HADDR(32), .W_HDATA(32), .DEPTH(1024), .WAIT_CYCLES(WAITS)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int          id;
    logic        is_read;
    logic        resp;
    int          waits;
    logic [31:0] rdata;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   beat_id = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s got=0x%08h want=0x%08h", name, act, req);
    end
  endtask

  // Drive one address phase, queue its expectation, and wait for acceptance.
  task automatic beat(input logic [1:0] trans, input logic wr, input logic [31:0] addr,
                      input logic [2:0] size, input logic [31:0] wdata,
                      input logic [31:0] exp_rdata, input logic exp_resp,
                      input int exp_waits, input bit push);
    exp_t e;
    int   guard;
    bus.ahbls_htrans = trans;
    bus.ahbls_hwrite = wr;
    bus.ahbls_haddr  = addr;
    bus.ahbls_hsize  = size;
    bus.ahbls_hburst = cur_burst;
    if (push) begin
      e.id = beat_id; e.is_read = !wr; e.resp = exp_resp;
      e.waits = exp_waits; e.rdata = exp_rdata;
      exp_q.push_back(e);
    end
    beat_id++;
    guard = 0;
    @(negedge clk);
    while (!bus.ahbls_hready && guard < 50) begin
      guard++;
      @(negedge clk);
    end
    chk("addr_accept", {31'd0, bus.ahbls_hready}, 32'd1);
    @(posedge clk); #1;
    if (wr) bus.ahbls_hwdata = wdata;
    bus.ahbls_htrans = HTRANS_IDLE;
  endtask

  task automatic wr_beat(input logic [1:0] trans, input logic [31:0] addr,
                         input logic [2:0] size, input logic [31:0] wdata);
    beat(trans, 1'b1, addr, size, wdata, 32'd0, 1'b0,
         (trans == HTRANS_NSEQ) ? WAITS : 0, 1'b1);
  endtask

  task automatic rd_beat(input logic [1:0] trans, input logic [31:0] addr,
                         input logic [31:0] exp_rdata);
    beat(trans, 1'b0, addr, HSIZE_WORD, 32'd0, exp_rdata, 1'b0,
         (trans == HTRANS_NSEQ) ? WAITS : 0, 1'b1);
  endtask

  task automatic idle(input int n);
    bus.ahbls_htrans = HTRANS_IDLE;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  // Monitor: tracks data phases and compares each completion to the queue.
  initial begin
    bit   dp;
    bit   after_rst;
    int   wcnt;
    exp_t e;
    dp = 0; after_rst = 0; wcnt = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        dp = 0; wcnt = 0; after_rst = 1;
      end else begin
        if (after_rst) begin
          chk("reset_hrdata", bus.ahbls_hrdata, 32'd0);
          after_rst = 0;
        end
        if (dp) begin
          if (!bus.ahbls_hready_resp) begin
            wcnt++;
          end else begin
            if (exp_q.size() == 0) begin
              checks++; errors++;
              $display("FAIL unexpected_response got=completion want=none");
            end else begin
              e = exp_q.pop_front();
              $display("txn %0d %s resp=%0d waits=%0d rdata=0x%08h", e.id,
                       e.is_read ? "rd" : "wr", bus.ahbls_hresp, wcnt, bus.ahbls_hrdata);
              chk($sformatf("txn%0d_hresp", e.id), {31'd0, bus.ahbls_hresp}, {31'd0, e.resp});
              chk($sformatf("txn%0d_waits", e.id), 32'(wcnt), 32'(e.waits));
              if (e.is_read && !e.resp)
                chk($sformatf("txn%0d_rdata", e.id), bus.ahbls_hrdata, e.rdata);
            end
            dp = 0; wcnt = 0;
          end
        end else begin
          chk("idle_hready_resp", {31'd0, bus.ahbls_hready_resp}, 32'd1);
          chk("idle_hresp", {31'd0, bus.ahbls_hresp}, 32'd0);
        end
        if (bus.ahbls_hready && bus.ahbls_htrans[1]) dp = 1;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  // Directed stimulus.
  initial begin
    bus.ahbls_htrans    = HTRANS_IDLE;
    bus.ahbls_haddr     = 32'd0;
    bus.ahbls_hwrite    = 1'b0;
    bus.ahbls_hsize     = HSIZE_WORD;
    bus.ahbls_hburst    = HBURST_SINGLE;
    bus.ahbls_hprot     = 4'b0011;
    bus.ahbls_hmastlock = 1'b0;
    bus.ahbls_hwdata    = 32'd0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    idle(2);

    // Single word write then read, two waits on each NSEQ.
    wr_beat(HTRANS_NSEQ, 32'h40, HSIZE_WORD, 32'hDEADBEEF);
    idle(1);
    rd_beat(HTRANS_NSEQ, 32'h40, 32'hDEADBEEF);
    idle(4);

    // WRAP4 write from 0x18, WRAP4 read from 0x10.
    cur_burst = HBURST_WRAP4;
    wr_beat(HTRANS_NSEQ, 32'h18, HSIZE_WORD, 32'd1);
    wr_beat(HTRANS_SEQ,  32'h1C, HSIZE_WORD, 32'd2);
    wr_beat(HTRANS_SEQ,  32'h10, HSIZE_WORD, 32'd3);
    wr_beat(HTRANS_SEQ,  32'h14, HSIZE_WORD, 32'd4);
    idle(1);
    rd_beat(HTRANS_NSEQ, 32'h10, 32'd3);
    rd_beat(HTRANS_SEQ,  32'h14, 32'd4);
    rd_beat(HTRANS_SEQ,  32'h18, 32'd1);
    rd_beat(HTRANS_SEQ,  32'h1C, 32'd2);
    idle(4);
    cur_burst = HBURST_SINGLE;

    // Aliasing modulo 4 KiB.
    rd_beat(HTRANS_NSEQ, 32'h0000_1010, 32'd3);
    idle(4);

    // Byte and halfword lanes, pipelined back to back.
    wr_beat(HTRANS_NSEQ, 32'h100, HSIZE_WORD, 32'h11223344);
    wr_beat(HTRANS_NSEQ, 32'h103, HSIZE_BYTE, 32'hAA000000);
    rd_beat(HTRANS_NSEQ, 32'h100, 32'hAA223344);
    wr_beat(HTRANS_NSEQ, 32'h102, HSIZE_HALF, 32'hBEEF0000);
    wr_beat(HTRANS_NSEQ, 32'h100, HSIZE_HALF, 32'h0000CAFE);
    rd_beat(HTRANS_NSEQ, 32'h100, 32'hBEEFCAFE);
    wr_beat(HTRANS_NSEQ, 32'h101, HSIZE_BYTE, 32'h00005500);
    rd_beat(HTRANS_NSEQ, 32'h100, 32'hBEEF55FE);
    idle(4);

    // Write immediately followed by read of the same word.
    wr_beat(HTRANS_NSEQ, 32'h80, HSIZE_WORD, 32'h5);
    rd_beat(HTRANS_NSEQ, 32'h80, 32'h5);
    idle(4);

    // Illegal transfers: misaligned word write/read, misaligned halfword write.
    beat(HTRANS_NSEQ, 1'b1, 32'h42, HSIZE_WORD, 32'h12345678, 32'd0, ILL_RESP, ILL_WAITS, 1'b1);
    idle(4);
    rd_beat(HTRANS_NSEQ, 32'h40, 32'hDEADBEEF);
    idle(4);
    beat(HTRANS_NSEQ, 1'b0, 32'h42, HSIZE_WORD, 32'd0, 32'd0, ILL_RESP, ILL_WAITS, 1'b1);
    idle(4);
    beat(HTRANS_NSEQ, 1'b1, 32'h101, HSIZE_HALF, 32'h77777777, 32'd0, ILL_RESP, ILL_WAITS, 1'b1);
    idle(4);
    rd_beat(HTRANS_NSEQ, 32'h100, 32'hBEEF55FE);
    idle(4);

    // Bus stalled by another responder: the address phase must be ignored.
    stall = 1'b1;
    bus.ahbls_htrans = HTRANS_NSEQ;
    bus.ahbls_hwrite = 1'b1;
    bus.ahbls_haddr  = 32'h40;
    bus.ahbls_hsize  = HSIZE_WORD;
    repeat (3) begin
      @(posedge clk); #1;
      bus.ahbls_hwdata = 32'h0;
    end
    bus.ahbls_htrans = HTRANS_IDLE;
    stall = 1'b0;
    idle(2);
    rd_beat(HTRANS_NSEQ, 32'h40, 32'hDEADBEEF);
    idle(4);

    // Reset during the WAIT state of a write: no commit, outputs reset.
    wr_beat(HTRANS_NSEQ, 32'h200, HSIZE_WORD, 32'h0);
    idle(4);
    beat(HTRANS_NSEQ, 1'b1, 32'h200, HSIZE_WORD, 32'hFFFFFFFF, 32'd0, 1'b0, 0, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    idle(2);
    rd_beat(HTRANS_NSEQ, 32'h200, 32'h0);
    idle(6);

    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
